// File: rtl/exa_crosb_out_arbiter.sv
// exa_crosb_out_arbiter
// Per-output-port round-robin arbiter for the crossbar. It watches the
// VALID/LAST lines of every competing input, grants one input at a time and
// holds that grant for a whole packet. It releases the grant when the LAST
// beat is accepted downstream, then rotates priority to the next input.
// SEL_o drives the select of the crossbar output mux.
//
// Optional feature: define EXA_OUT_ARB_TIMEOUT_EN to build a watchdog. The
// watchdog breaks a lock whose granted input has stopped presenting VALID
// for timeout_cycles consecutive cycles. Without the macro TIMEOUT_o is
// tied to 0, and a lock releases only on LAST.

module exa_crosb_out_arbiter #(
    parameter int input_num      = 16,
    parameter int sel_width      = (input_num > 1) ? $clog2(input_num) : 1,
    parameter int timeout_cycles = 255
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [input_num-1:0] VALID_i,
    input  logic [input_num-1:0] LAST_i,
    input  logic                 READY_i,
    output logic [sel_width-1:0] SEL_o,
    output logic [input_num-1:0] GRANT_o,
    output logic                 BUSY_o,
    output logic                 TIMEOUT_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_next;
    logic [sel_width-1:0] ptr_q, ptr_next;
    logic [sel_width-1:0] sel_q, sel_next;
    logic [input_num-1:0] grant_q, grant_next;
    logic                 busy_q, busy_next;

    // Round-robin search result
    logic                 win_found;
    logic [sel_width-1:0] win_idx;

    // Beat handshake on the currently selected input
    logic                 sel_valid;
    logic                 beat_accept;
    logic                 last_accept;
    logic [sel_width-1:0] ptr_after_sel;

`ifdef EXA_OUT_ARB_TIMEOUT_EN
    localparam int cnt_width = $clog2(timeout_cycles + 1);

    logic [cnt_width-1:0] wd_cnt_q, wd_cnt_next;
    logic                 timeout_q, timeout_next;
    logic                 wd_hit;
`endif

    assign sel_valid   = VALID_i[sel_q];
    assign beat_accept = sel_valid & READY_i;
    assign last_accept = beat_accept & LAST_i[sel_q];

    // The pointer wraps by compare, so input_num need not be a power of two
    assign ptr_after_sel = (int'(sel_q) == input_num - 1) ? '0
                                                          : sel_q + sel_width'(1);

`ifdef EXA_OUT_ARB_TIMEOUT_EN
    assign wd_hit = (wd_cnt_q == cnt_width'(timeout_cycles));
`endif

    // First requesting input at or above the pointer, wrapping to input 0
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < input_num; i++) begin
            int idx;
            idx = int'(ptr_q) + i;
            if (idx >= input_num) begin
                idx = idx - input_num;
            end
            if (!win_found && VALID_i[idx]) begin
                win_found = 1'b1;
                win_idx   = sel_width'(idx);
            end
        end
    end

    // Next-state and next-output logic for the IDLE/LOCKED machine
    always_comb begin
        state_next = state_q;
        ptr_next   = ptr_q;
        sel_next   = sel_q;
        grant_next = grant_q;
        busy_next  = busy_q;
`ifdef EXA_OUT_ARB_TIMEOUT_EN
        wd_cnt_next  = wd_cnt_q;
        timeout_next = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_next          = LOCKED;
                    sel_next            = win_idx;
                    grant_next          = '0;
                    grant_next[win_idx] = 1'b1;
                    busy_next           = 1'b1;
`ifdef EXA_OUT_ARB_TIMEOUT_EN
                    wd_cnt_next = '0;
`endif
                end
            end

            LOCKED: begin
`ifdef EXA_OUT_ARB_TIMEOUT_EN
                // Count only cycles where the granted input presents nothing;
                // downstream backpressure with VALID high is not a stall.
                if (sel_valid) begin
                    wd_cnt_next = '0;
                end else if (!wd_hit) begin
                    wd_cnt_next = wd_cnt_q + cnt_width'(1);
                end

                if (last_accept || wd_hit) begin
                    state_next   = IDLE;
                    grant_next   = '0;
                    busy_next    = 1'b0;
                    ptr_next     = ptr_after_sel;
                    wd_cnt_next  = '0;
                    timeout_next = ~last_accept;
                end
`else
                if (last_accept) begin
                    state_next = IDLE;
                    grant_next = '0;
                    busy_next  = 1'b0;
                    ptr_next   = ptr_after_sel;
                end
`endif
            end

            default: begin
                state_next = IDLE;
                grant_next = '0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State, pointer and registered outputs; reset drops any lock at once
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            ptr_q   <= ptr_next;
            sel_q   <= sel_next;
            grant_q <= grant_next;
            busy_q  <= busy_next;
        end
    end

`ifdef EXA_OUT_ARB_TIMEOUT_EN
    // Watchdog counter and its one-cycle timeout pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_next;
            timeout_q <= timeout_next;
        end
    end

    assign TIMEOUT_o = timeout_q;
`else
    assign TIMEOUT_o = 1'b0;
`endif

    assign SEL_o   = sel_q;
    assign GRANT_o = grant_q;
    assign BUSY_o  = busy_q;

endmodule

// File: tb/tb_exa_crosb_out_arbiter.sv
// Testbench for exa_crosb_out_arbiter (16 inputs, timeout_cycles = 4).
// Expected grants are pushed into a queue as stimulus is issued. A monitor
// pops one entry each time a new lock appears and compares SEL_o/GRANT_o.
// Timing-sensitive points are checked inline against hand-computed values.

module tb_exa_crosb_out_arbiter;

    localparam int N  = 16;
    localparam int SW = 4;

    logic          clk;
    logic          resetn;
    logic [N-1:0]  VALID_i;
    logic [N-1:0]  LAST_i;
    logic          READY_i;
    logic [SW-1:0] SEL_o;
    logic [N-1:0]  GRANT_o;
    logic          BUSY_o;
    logic          TIMEOUT_o;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];
    logic prev_busy = 1'b0;

    exa_crosb_out_arbiter #(
        .input_num      (N),
        .sel_width      (SW),
        .timeout_cycles (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .VALID_i   (VALID_i),
        .LAST_i    (LAST_i),
        .READY_i   (READY_i),
        .SEL_o     (SEL_o),
        .GRANT_o   (GRANT_o),
        .BUSY_o    (BUSY_o),
        .TIMEOUT_o (TIMEOUT_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one packet on input s with READY held high; the grant edge is the
    // first tick, then one edge per beat, LAST on the final beat.
    task automatic run_pkt(input int s, input int beats);
        tick();
        chk("grant_busy", 32'(BUSY_o), 32'd1);
        for (int b = 0; b < beats; b++) begin
            LAST_i = (b == beats - 1) ? (N'(1) << s) : '0;
            tick();
            if (b < beats - 1) begin
                chk("hold_sel", 32'(SEL_o), 32'(s));
            end else begin
                chk("release_busy", 32'(BUSY_o), 32'd0);
                chk("release_grant", 32'(GRANT_o), 32'd0);
            end
        end
        LAST_i = '0;
    endtask

    // Scoreboard monitor: each new lock must match the next expected grant
    always @(negedge clk) begin
        if (BUSY_o && !prev_busy) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_grant", 32'(SEL_o), 32'hFFFF_FFFF);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("sb_sel", 32'(SEL_o), 32'(e));
                chk("sb_grant", 32'(GRANT_o), 32'(1) << e);
            end
        end
        prev_busy <= BUSY_o;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int cnt;
        resetn  = 1'b0;
        VALID_i = '0;
        LAST_i  = '0;
        READY_i = 1'b1;
        tick();
        tick();
        chk("rst_sel", 32'(SEL_o), 32'd0);
        chk("rst_grant", 32'(GRANT_o), 32'd0);
        chk("rst_busy", 32'(BUSY_o), 32'd0);
        chk("rst_timeout", 32'(TIMEOUT_o), 32'd0);

        // Idle with no requests
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_busy", 32'(BUSY_o), 32'd0);
            chk("idle_grant", 32'(GRANT_o), 32'd0);
        end
        chk("idle_sel", 32'(SEL_o), 32'd0);

        // Two requesters alternate 0, 4, 0, 4 with 3-beat packets
        VALID_i = 16'h0011;
        exp_q.push_back(0); run_pkt(0, 3);
        exp_q.push_back(4); run_pkt(4, 3);
        exp_q.push_back(0); run_pkt(0, 3);
        exp_q.push_back(4); run_pkt(4, 3);

        // Pointer 5 -> input 14 wins, leaving pointer at 15; then 15 and 0
        VALID_i = 16'h4000;
        exp_q.push_back(14); run_pkt(14, 1);
        VALID_i = 16'h8001;
        exp_q.push_back(15); run_pkt(15, 2);
        exp_q.push_back(0);  run_pkt(0, 1);

        // Input 2 locked under toggling READY while input 5 keeps requesting
        VALID_i = 16'h0024;
        exp_q.push_back(2);
        tick();
        chk("bp_grant_busy", 32'(BUSY_o), 32'd1);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            READY_i = k[0];
            LAST_i  = (cnt == 2) ? 16'h0004 : 16'h0000;
            tick();
            if (READY_i) cnt++;
            if (k < 5) begin
                chk("bp_hold_sel", 32'(SEL_o), 32'd2);
                chk("bp_hold_busy", 32'(BUSY_o), 32'd1);
            end else begin
                chk("bp_release_busy", 32'(BUSY_o), 32'd0);
            end
        end
        READY_i = 1'b1;
        LAST_i  = '0;
        exp_q.push_back(5);
        tick();
        chk("bp_next_sel", 32'(SEL_o), 32'd5);
        LAST_i = 16'h0020;
        tick();
        chk("bp_next_release", 32'(BUSY_o), 32'd0);
        LAST_i = '0;

        // Input 3 locked (pointer 6 wraps to 3), then drops VALID
        VALID_i = 16'h0008;
        exp_q.push_back(3);
        tick();
        chk("stall_grant_sel", 32'(SEL_o), 32'd3);
        VALID_i = '0;
`ifdef EXA_OUT_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wd_hold_busy", 32'(BUSY_o), 32'd1);
            chk("wd_no_pulse", 32'(TIMEOUT_o), 32'd0);
        end
        tick();
        chk("wd_release_busy", 32'(BUSY_o), 32'd0);
        chk("wd_pulse", 32'(TIMEOUT_o), 32'd1);
        tick();
        chk("wd_pulse_end", 32'(TIMEOUT_o), 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (BUSY_o !== 1'b1 || TIMEOUT_o !== 1'b0) begin
                chk("stall_hold", {30'd0, BUSY_o, TIMEOUT_o}, 32'd2);
            end
        end
        chk("stall_busy_100", 32'(BUSY_o), 32'd1);
        chk("stall_sel_100", 32'(SEL_o), 32'd3);
        VALID_i = 16'h0008;
        LAST_i  = 16'h0008;
        tick();
        chk("stall_release", 32'(BUSY_o), 32'd0);
        LAST_i = '0;
`endif
        // Pointer must now be 4: with 3 and 4 requesting, 4 wins
        VALID_i = 16'h0018;
        exp_q.push_back(4); run_pkt(4, 1);

        // Reset in the middle of an input-7 packet (pointer 5 -> 7)
        VALID_i = 16'h0080;
        exp_q.push_back(7);
        tick();
        tick();
        chk("mid_busy", 32'(BUSY_o), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_grant", 32'(GRANT_o), 32'd0);
        chk("async_rst_busy", 32'(BUSY_o), 32'd0);
        chk("async_rst_sel", 32'(SEL_o), 32'd0);
        tick();
        resetn = 1'b1;
        exp_q.push_back(7);
        tick();
        chk("post_rst_sel", 32'(SEL_o), 32'd7);
        chk("post_rst_busy", 32'(BUSY_o), 32'd1);
        LAST_i = 16'h0080;
        tick();
        chk("post_rst_release", 32'(BUSY_o), 32'd0);
        LAST_i  = '0;
        VALID_i = '0;
        tick();
        tick();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exa_crosb_out_arbiter.md
# exa_crosb_out_arbiter

Per-output-port round-robin arbiter that drives the select of the crossbar output mux. It watches the valid/last lines of all inputs competing for one output and grants one input at a time. It holds the grant for a whole packet, until the LAST beat is accepted downstream, then rotates priority. One instance sits beside each crossbar output mux and feeds its SEL_i.

## Interface
- `input_num`, default 16: number of competing inputs.
- `sel_width`, default `log2(input_num)`: width of the select output.
- `timeout_cycles`, default 255: watchdog limit. Used only when the macro in Configuration is defined.

Ports:
- `clk`  in  1: the single clock. All state updates on its rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `VALID_i`  in  input_num: per-input beat valid; doubles as the request line.
- `LAST_i`  in  input_num: per-input last-beat flag; qualified by VALID_i.
- `READY_i`  in  1: downstream of the mux accepts the current beat.
- `SEL_o`  out  sel_width: index of the granted input; connects to the mux SEL_i.
- `GRANT_o`  out  input_num: one-hot grant; all zero when idle.
- `BUSY_o`  out  1: a packet lock is held.
- `TIMEOUT_o`  out  1: one-cycle pulse when the watchdog breaks a lock. Tied to 0 without the macro.

## Operation
- Reset values: SEL_o=0, GRANT_o=0, BUSY_o=0, TIMEOUT_o=0. The round-robin pointer resets to 0 and the state to IDLE.
- State machine with two states, IDLE and LOCKED.
- IDLE behaviour:
  - If any VALID_i bit is set, select the first set bit searching upward from the pointer, wrapping from input_num-1 to 0.
  - Register the winner into SEL_o and GRANT_o, set BUSY_o, and go to LOCKED.
  - If no VALID_i bit is set, stay in IDLE with all outputs unchanged.
- LOCKED behaviour:
  - A beat is accepted when VALID_i[SEL_o] & READY_i.
  - An accepted beat with LAST_i[SEL_o]=1 ends the packet. GRANT_o clears, BUSY_o clears, and the state returns to IDLE.
  - On release the pointer becomes SEL_o+1, or 0 if SEL_o = input_num-1. Wrap is by compare, not by bit overflow, so non-power-of-two input_num works.
- SEL_o holds its last value while idle. Only GRANT_o and BUSY_o indicate validity.
- In LOCKED, VALID_i from non-granted inputs is ignored.
- If the granted input drops VALID mid-packet, the lock is held indefinitely unless the watchdog is compiled in.
- A single-beat packet (VALID & LAST & READY on the first granted cycle) releases exactly like a multi-beat packet.
- If resetn is asserted mid-packet, all state clears immediately and the lock is dropped. No completion is attempted.

## Timing
- Grant latency: any VALID_i seen in IDLE at edge t gives GRANT_o, SEL_o and BUSY_o valid after edge t+1.
- Release: a LAST beat accepted at edge t gives BUSY_o=0 after t+1. The earliest next grant is visible after t+2, so there is one dead cycle per packet.
- SEL_o is stable for the entire lock. The mux output is therefore glitch-free between the first and LAST beat.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Configuration
- Macro `EXA_OUT_ARB_TIMEOUT_EN`.
- When defined:
  - A counter of width log2(timeout_cycles+1) runs in LOCKED.
  - It increments on each cycle where VALID_i[SEL_o]=0. It resets to 0 on any cycle where VALID_i[SEL_o]=1, and on entry to LOCKED.
  - Cycles with VALID=1 and READY_i=0 (downstream backpressure) do not count.
  - When the counter equals timeout_cycles, the next edge releases the lock exactly as a LAST release does, including the pointer advance. TIMEOUT_o is high for that one cycle, coincident with BUSY_o falling.
- When undefined: no counter is built, TIMEOUT_o is constant 0, and a lock releases only on LAST.

## Test plan
- Reset, then VALID_i=16'h0000 for 10 cycles: outputs stay at reset values and BUSY_o=0.
- VALID_i=16'h0011 held, each packet 3 beats, READY_i=1: grants alternate 0, 4, 0, 4. Each grant appears 1 cycle after IDLE and carries 3 accepted beats; there is 1 dead cycle between packets.
- Pointer at 15, VALID_i=16'h8001: input 15 is granted. After its LAST the pointer becomes 0 and input 0 is granted next.
- Input 2 locked, READY_i toggling 1/0 and VALID_i[5]=1 throughout: SEL_o stays 2 until LAST_i[2] is accepted, and input 5 is granted 2 cycles later.
- With the macro defined and timeout_cycles=4: input 3 is locked and then drops VALID. BUSY_o falls and TIMEOUT_o pulses after exactly 4 counted idle cycles plus 1 edge; the pointer becomes 4. Without the macro, the lock holds for 100 cycles.
- resetn asserted while input 7 is mid-packet: GRANT_o=0, BUSY_o=0 and SEL_o=0 immediately. After release with VALID_i=16'h0080, input 7 is granted 1 cycle later, starting from pointer 0.
